regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data width of every write-data port.
REQ-002 Parameter: AW, 5, register address width; register 0 is hard-wired zero.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, the single clock; rst input 1, synchronous active-high reset.
REQ-004 alu_valid  input  1  ALU writeback request.
REQ-005 alu_rd_addr / alu_data  input  AW / XLEN  ALU destination and result.
REQ-006 alu_ready  output  1  ALU request accepted this cycle.
REQ-007 lsu_valid  input  1  load-unit writeback request.
REQ-008 lsu_rd_addr / lsu_data  input  AW / XLEN  load destination and data.
REQ-009 lsu_ready  output  1  load request accepted this cycle.
REQ-010 write_en / rd_addr / rd  output  1 / AW / XLEN  registered register-file write port.
REQ-011 busy_mask  output  2^AW  bit n set while a write to register n is held in the output stage.
REQ-012 last_grant  output  1  requester granted most recently (0 = ALU, 1 = LSU).

Function
REQ-013 Handshake SHALL be valid/ready: a transfer occurs on a cycle where valid and ready are both high; ready is combinational from the valids and the arbiter state, and never depends on ready itself.
REQ-014 At most one of alu_ready and lsu_ready SHALL be high per cycle; with a single valid requester, that requester SHALL be granted the same cycle.
REQ-015 Accepted request SHALL appear on write_en/rd_addr/rd exactly 1 cycle later (output register); the output stage drains every cycle, so no backpressure from the register file.
REQ-016 An accepted request with rd_addr = 0 SHALL be consumed (ready high) but SHALL produce write_en = 0 and no busy_mask bit.
REQ-017 With no transfer in a cycle, write_en SHALL be 0 the next cycle; rd_addr and rd hold their previous values.
REQ-018 busy_mask SHALL be the one-hot decode of rd_addr when write_en = 1, else all zero.
REQ-019 Arbitration SHALL be a 2-state machine, PRI_ALU and PRI_LSU, naming the requester that wins a tie; a tie is both valids high in one cycle.
REQ-020 The state machine SHALL move to PRI_LSU after an ALU grant and to PRI_ALU after an LSU grant; with no grant it holds.
REQ-021 last_grant SHALL update only on a grant and SHALL hold otherwise.
REQ-022 A request SHALL NOT be starved: a continuously valid requester is granted within 2 cycles of asserting valid.
REQ-023 Same rd_addr from both requesters in one cycle: only the granted one writes that cycle; the loser writes in a later cycle, and that later value is final.
REQ-024 Request inputs SHALL be sampled only on the accepting cycle; changes to the inputs while not ready have no effect.

Reset
REQ-025 While rst is high at a clk edge: write_en = 0, rd_addr = 0, rd = 0, busy_mask = 0, last_grant = 0, state = PRI_ALU.
REQ-026 alu_ready and lsu_ready SHALL be 0 on any cycle in which rst is high, so no request is accepted.
REQ-027 A write registered before rst asserts SHALL be discarded; write_en is 0 in the cycle after reset.
REQ-028 After rst deasserts, the first tie SHALL be granted to the ALU.

Configuration
REQ-029 Macro: WB_ARB_RR_EN. When defined, arbitration SHALL be the round-robin of REQ-019 to REQ-022.
REQ-030 When WB_ARB_RR_EN is not defined, the ALU SHALL always win ties: fixed priority, the state machine is removed, and last_grant still tracks grants.
REQ-031 Without WB_ARB_RR_EN, REQ-022 SHALL NOT apply to the LSU; all other requirements are unchanged.

Verification
REQ-032 Single ALU: alu_valid=1, alu_rd_addr=5, alu_data=0xDEADBEEF for one cycle -> alu_ready=1 that cycle; next cycle write_en=1, rd_addr=5, rd=0xDEADBEEF, busy_mask=0x00000020.
REQ-033 Tie with RR (WB_ARB_RR_EN defined): both valid for 4 cycles, ALU rd=1 and LSU rd=2 -> grant order ALU, LSU, ALU, LSU; rd_addr sequence 1,2,1,2.
REQ-034 Fixed priority (WB_ARB_RR_EN undefined): both valid for 3 cycles -> alu_ready=1 every cycle, lsu_ready=0 throughout.
REQ-035 x0 write: lsu_valid=1, lsu_rd_addr=0, lsu_data=0x12345678 -> lsu_ready=1; next cycle write_en=0, busy_mask=0.
REQ-036 Reset mid-operation: grant ALU rd=7, then rst=1 on the next edge -> write_en=0, busy_mask=0, both readies 0 during reset; after release a tie grants the ALU.
REQ-037 Same destination: ALU rd=3 data=0xA and LSU rd=3 data=0xB in the same cycle with RR from reset -> writes 0xA, then 0xB on the following cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU requesters, the arbiter and the register-file write port.
interface regfile_wb_arbiter_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    localparam int unsigned NREG = 1 << AW;

    logic            alu_valid;
    logic [AW-1:0]   alu_rd_addr;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            lsu_valid;
    logic [AW-1:0]   lsu_rd_addr;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;

    logic            write_en;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd;
    logic [NREG-1:0] busy_mask;
    logic            last_grant;

    modport master (
        output alu_valid, alu_rd_addr, alu_data,
        output lsu_valid, lsu_rd_addr, lsu_data,
        input  alu_ready, lsu_ready,
        input  write_en, rd_addr, rd, busy_mask, last_grant
    );

    modport slave (
        input  alu_valid, alu_rd_addr, alu_data,
        input  lsu_valid, lsu_rd_addr, lsu_data,
        output alu_ready, lsu_ready,
        output write_en, rd_addr, rd, busy_mask, last_grant
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU/LSU) writeback arbiter with a registered register-file write port.
// WB_ARB_RR_EN selects round-robin tie-breaking; otherwise the ALU always wins ties.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int unsigned NREG = 1 << AW;

    logic            tie_lsu_c;
    logic            grant_alu_c;
    logic            grant_lsu_c;
    logic            xfer_c;
    logic [AW-1:0]   win_addr_c;
    logic [XLEN-1:0] win_data_c;

`ifdef WB_ARB_RR_EN
    typedef enum logic {PRI_ALU = 1'b0, PRI_LSU = 1'b1} pri_e;

    pri_e state_q;
    pri_e state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRI_ALU;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority flips to the other requester after every grant; holds when idle.
    always_comb begin
        state_d = state_q;
        if (grant_alu_c) begin
            state_d = PRI_LSU;
        end else if (grant_lsu_c) begin
            state_d = PRI_ALU;
        end
    end

    assign tie_lsu_c = (state_q == PRI_LSU);
`else
    assign tie_lsu_c = 1'b0;
`endif

    // Grant logic: ready depends only on the valids, reset and tie priority.
    always_comb begin
        grant_alu_c   = 1'b0;
        grant_lsu_c   = 1'b0;
        bus.alu_ready = 1'b0;
        bus.lsu_ready = 1'b0;
        if (!rst) begin
            grant_alu_c = bus.alu_valid && !(bus.lsu_valid && tie_lsu_c);
            grant_lsu_c = bus.lsu_valid && !grant_alu_c;
        end
        bus.alu_ready = grant_alu_c;
        bus.lsu_ready = grant_lsu_c;
    end

    assign xfer_c     = grant_alu_c || grant_lsu_c;
    assign win_addr_c = grant_lsu_c ? bus.lsu_rd_addr : bus.alu_rd_addr;
    assign win_data_c = grant_lsu_c ? bus.lsu_data    : bus.alu_data;

    // Output stage drains every cycle; writes to x0 are consumed silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.write_en   <= 1'b0;
            bus.rd_addr    <= '0;
            bus.rd         <= '0;
            bus.busy_mask  <= '0;
            bus.last_grant <= 1'b0;
        end else begin
            bus.write_en  <= xfer_c && (win_addr_c != '0);
            bus.busy_mask <= (xfer_c && (win_addr_c != '0)) ? (NREG'(1) << win_addr_c) : '0;
            if (xfer_c) begin
                bus.rd_addr    <= win_addr_c;
                bus.rd         <= win_data_c;
                bus.last_grant <= grant_lsu_c;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; expectations follow WB_ARB_RR_EN.
module tb_regfile_wb_arbiter;
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    regfile_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_rd_addr = '0;
        bus.alu_data    = '0;
        bus.lsu_valid   = 1'b0;
        bus.lsu_rd_addr = '0;
        bus.lsu_data    = '0;
    endtask

    initial begin
        logic exp_alu;
        total = 0;
        bad   = 0;
        idle();
        rst = 1'b1;
        tick();
        bus.alu_valid = 1'b1;
        bus.lsu_valid = 1'b1;
        #1;
        chk("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
        chk("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
        tick();
        chk("rst_write_en", 64'(bus.write_en), 64'd0);
        chk("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
        chk("rst_rd", 64'(bus.rd), 64'd0);
        chk("rst_busy", 64'(bus.busy_mask), 64'd0);
        chk("rst_last_grant", 64'(bus.last_grant), 64'd0);
        idle();
        rst = 1'b0;
        tick();

        // Single ALU write
        bus.alu_valid   = 1'b1;
        bus.alu_rd_addr = 5'd5;
        bus.alu_data    = 32'hDEADBEEF;
        #1;
        chk("alu_single_ready", 64'(bus.alu_ready), 64'd1);
        chk("alu_single_lsu_ready", 64'(bus.lsu_ready), 64'd0);
        tick();
        idle();
        chk("alu_single_we", 64'(bus.write_en), 64'd1);
        chk("alu_single_addr", 64'(bus.rd_addr), 64'd5);
        chk("alu_single_rd", 64'(bus.rd), 64'hDEADBEEF);
        chk("alu_single_busy", 64'(bus.busy_mask), 64'h20);
        chk("alu_single_lg", 64'(bus.last_grant), 64'd0);
        tick();
        chk("idle_we", 64'(bus.write_en), 64'd0);
        chk("idle_addr_hold", 64'(bus.rd_addr), 64'd5);
        chk("idle_rd_hold", 64'(bus.rd), 64'hDEADBEEF);
        chk("idle_busy", 64'(bus.busy_mask), 64'd0);

        // LSU write to x0
        bus.lsu_valid   = 1'b1;
        bus.lsu_rd_addr = 5'd0;
        bus.lsu_data    = 32'h12345678;
        #1;
        chk("x0_lsu_ready", 64'(bus.lsu_ready), 64'd1);
        tick();
        idle();
        chk("x0_we", 64'(bus.write_en), 64'd0);
        chk("x0_busy", 64'(bus.busy_mask), 64'd0);
        chk("x0_last_grant", 64'(bus.last_grant), 64'd1);

        // Four-cycle tie, ALU rd=1 vs LSU rd=2
        bus.alu_valid   = 1'b1;
        bus.alu_rd_addr = 5'd1;
        bus.alu_data    = 32'h11;
        bus.lsu_valid   = 1'b1;
        bus.lsu_rd_addr = 5'd2;
        bus.lsu_data    = 32'h22;
        for (int i = 0; i < 4; i++) begin
`ifdef WB_ARB_RR_EN
            exp_alu = (i % 2 == 0);
`else
            exp_alu = 1'b1;
`endif
            #1;
            chk($sformatf("tie%0d_alu_ready", i), 64'(bus.alu_ready), 64'(exp_alu));
            chk($sformatf("tie%0d_lsu_ready", i), 64'(bus.lsu_ready), 64'(!exp_alu));
            tick();
            chk($sformatf("tie%0d_addr", i), 64'(bus.rd_addr), exp_alu ? 64'd1 : 64'd2);
            chk($sformatf("tie%0d_rd", i), 64'(bus.rd), exp_alu ? 64'h11 : 64'h22);
            chk($sformatf("tie%0d_we", i), 64'(bus.write_en), 64'd1);
        end
        idle();
`ifdef WB_ARB_RR_EN
        chk("tie_last_grant", 64'(bus.last_grant), 64'd1);
`else
        chk("tie_last_grant", 64'(bus.last_grant), 64'd0);
`endif

        // Reset mid-operation
        bus.alu_valid   = 1'b1;
        bus.alu_rd_addr = 5'd7;
        bus.alu_data    = 32'h77;
        #1;
        chk("mid_alu_ready", 64'(bus.alu_ready), 64'd1);
        tick();
        chk("mid_we_before_rst", 64'(bus.write_en), 64'd1);
        chk("mid_busy_before_rst", 64'(bus.busy_mask), 64'h80);
        rst = 1'b1;
        bus.lsu_valid = 1'b1;
        #1;
        chk("mid_rst_alu_ready", 64'(bus.alu_ready), 64'd0);
        chk("mid_rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
        tick();
        chk("mid_rst_we", 64'(bus.write_en), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy_mask), 64'd0);
        chk("mid_rst_addr", 64'(bus.rd_addr), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_tie_alu", 64'(bus.alu_ready), 64'd1);
        chk("post_rst_tie_lsu", 64'(bus.lsu_ready), 64'd0);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Same destination from both requesters
        bus.alu_valid   = 1'b1;
        bus.alu_rd_addr = 5'd3;
        bus.alu_data    = 32'hA;
        bus.lsu_valid   = 1'b1;
        bus.lsu_rd_addr = 5'd3;
        bus.lsu_data    = 32'hB;
        #1;
        chk("same_alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("same_lsu_ready", 64'(bus.lsu_ready), 64'd0);
        tick();
        bus.alu_valid = 1'b0;
        chk("same_first_rd", 64'(bus.rd), 64'hA);
        chk("same_first_busy", 64'(bus.busy_mask), 64'h8);
        #1;
        chk("same_lsu_ready2", 64'(bus.lsu_ready), 64'd1);
        tick();
        idle();
        chk("same_second_rd", 64'(bus.rd), 64'hB);
        chk("same_second_we", 64'(bus.write_en), 64'd1);
        chk("same_second_lg", 64'(bus.last_grant), 64'd1);
        tick();
        chk("same_drain_we", 64'(bus.write_en), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
